rc4_keystream_arbiter: RTL and testbench
========================================

Name: rc4_keystream_arbiter

Overview:
- Controller and arbiter in front of one shared RC4-style keystream engine (S-box init, key mix, byte generation).
- Sequences key loading into the engine and starts its key-schedule phase.
- Then serves keystream bytes to NREQ requesters (e.g. cipher and plain channels) with round-robin fairness, one byte per grant.
- Flags an engine hang with a watchdog.

Parameters:
KEY_LEN, 32, key bytes loaded per (re)key; key address width = clog2(KEY_LEN)
NREQ, 2, number of keystream requesters (2..8)
TIMEOUT, 255, max cycles waiting on eng_setup_done or eng_ks_valid before error
TW, 8, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
key_valid  in  1  key byte strobe, one byte per cycle
key_in  in  8  key byte
rekey  in  1  pulse: reload key (honoured only in ARB)
finish  in  1  level: no more traffic; go to DONE when idle
req  in  NREQ  per-requester keystream request, level, held until its gnt
gnt  out  NREQ  one-hot pulse, same cycle as ks_valid, marks the recipient
ks_valid  out  1  one-cycle pulse: ks_out valid
ks_out  out  8  keystream byte
eng_key_we  out  1  key write strobe to engine
eng_key_addr  out  clog2(KEY_LEN)  key write address
eng_key_data  out  8  key write data
eng_setup_start  out  1  one-cycle pulse: engine runs S-box init + key mix
eng_setup_done  in  1  engine key-schedule complete (pulse)
eng_gen  out  1  one-cycle pulse: produce next keystream byte
eng_ks_valid  in  1  engine keystream byte valid (pulse)
eng_ks  in  8  engine keystream byte
busy  out  1  high in every state except IDLE, DONE, ERROR
done  out  1  high in DONE
err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE. All outputs 0. Key counter 0. RR pointer = NREQ-1, so requester 0 has first priority. Watchdog 0.
- States: IDLE, KEYLOAD, SETUP, WAITSETUP, ARB, GEN, WAITKS, DONE, ERROR.
- IDLE/KEYLOAD, key load:
  - Each cycle with key_valid=1, register eng_key_we=1, eng_key_addr=cnt, eng_key_data=key_in (1-cycle latency); cnt++.
  - The first key_valid moves IDLE->KEYLOAD.
  - The write of byte KEY_LEN-1 moves the FSM to SETUP and clears cnt.
  - key_valid=0 mid-load pauses; no timeout in KEYLOAD.
- SETUP: eng_setup_start=1 for exactly one cycle -> WAITSETUP.
- WAITSETUP: wait for eng_setup_done -> ARB.
- ARB:
  - If any req bit is set, pick the first set bit searching from ptr+1 modulo NREQ. Register the index, ptr<=index -> GEN.
  - Else if rekey -> KEYLOAD, with cnt=0 and done cleared.
  - Else if finish -> DONE.
  - A request beats rekey/finish when both occur in the same cycle.
- GEN: eng_gen=1 for one cycle -> WAITKS.
- WAITKS: on eng_ks_valid, ks_out<=eng_ks, ks_valid=1, gnt[index]=1, all for one cycle on the next edge -> ARB.
- Latency: ARB decision to ks_valid = 2 + engine latency cycles. With a 1-cycle engine, back-to-back bytes arrive every 4 cycles.
- A requester must hold req until its gnt. Dropping req after arbitration still completes the grant; that byte is delivered and then lost.
- gnt is never multi-hot. A gnt bit is never set for a requester that was not selected.
- Watchdog:
  - Counts cycles in WAITSETUP and WAITKS; clears on state entry.
  - When it reaches TIMEOUT without the awaited pulse -> ERROR: err=1, all strobes 0, state held until rst.
  - A pulse arriving in the same cycle the count reaches TIMEOUT counts as success.
- eng_setup_done/eng_ks_valid pulses outside their wait states are ignored.
- DONE: done=1, busy=0. rekey -> KEYLOAD, done=0. Other inputs ignored.
- key_valid outside IDLE/KEYLOAD is ignored.
- rst at any time: immediate return to reset values. The engine must be re-keyed.
- ks_out holds its last value between pulses.

Test Plan:
- Key load: 32 bytes 0x00..0x1F, with key_valid low for 3 cycles after byte 10 -> 32 eng_key_we writes, addr k carries data k; one eng_setup_start pulse after the last write.
- Setup plus single request: engine model answers setup_done 5 cycles after start; req=01; engine returns 0xA5 one cycle after eng_gen -> ks_out=0xA5, ks_valid=1, gnt=01 once; ptr=0.
- Round-robin: req=11 held, engine returns 0x10,0x11,0x12,0x13 -> gnt sequence 01,10,01,10, each byte at 4-cycle spacing.
- Priority versus finish/rekey: finish=1 and req=10 in the same ARB cycle -> byte served to requester 1 first, then DONE with done=1, busy=0. rekey in DONE -> KEYLOAD, done=0.
- Watchdog: engine never asserts eng_ks_valid, TIMEOUT=255 -> err=1 exactly 255 cycles after WAITKS entry; no ks_valid; state stuck until rst.
- Async reset mid-WAITKS -> all outputs 0 immediately, without a clock edge. The next key load restarts at addr 0.

Source files
------------

// File: rtl/rc4_keystream_arbiter.sv
// rc4_keystream_arbiter: sequences key loading and setup of a shared RC4-style
// keystream engine, then hands keystream bytes to NREQ requesters in
// round-robin order, one byte per grant. A watchdog traps a hung engine.
module rc4_keystream_arbiter #(
    parameter int unsigned KEY_LEN = 32,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    input  logic [7:0]                  key_in,
    input  logic                        rekey,
    input  logic                        finish,
    input  logic [NREQ-1:0]             req,
    output logic [NREQ-1:0]             gnt,
    output logic                        ks_valid,
    output logic [7:0]                  ks_out,
    output logic                        eng_key_we,
    output logic [$clog2(KEY_LEN)-1:0]  eng_key_addr,
    output logic [7:0]                  eng_key_data,
    output logic                        eng_setup_start,
    input  logic                        eng_setup_done,
    output logic                        eng_gen,
    input  logic                        eng_ks_valid,
    input  logic [7:0]                  eng_ks,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned AW = $clog2(KEY_LEN);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [3:0] {
        IDLE,
        KEYLOAD,
        SETUP,
        WAITSETUP,
        ARB,
        GEN,
        WAITKS,
        DONE,
        ERROR
    } state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   sel;
    logic [TW-1:0]   wd;

    logic [IW-1:0]   pick;
    logic [IW-1:0]   pick_idx;
    logic            found;

    // Round-robin search: first requester set, starting just after the last winner.
    always_comb begin
        pick     = ptr;
        pick_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            pick_idx = IW'((32'(ptr) + i) % NREQ);
            if (!found && req[pick_idx]) begin
                pick  = pick_idx;
                found = 1'b1;
            end
        end
    end

    // Controller FSM with registered engine strobes, grant and keystream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            ptr             <= IW'(NREQ - 1);
            sel             <= '0;
            wd              <= '0;
            eng_key_we      <= 1'b0;
            eng_key_addr    <= '0;
            eng_key_data    <= '0;
            eng_setup_start <= 1'b0;
            eng_gen         <= 1'b0;
            ks_valid        <= 1'b0;
            ks_out          <= '0;
            gnt             <= '0;
        end else begin
            eng_key_we      <= 1'b0;
            eng_setup_start <= 1'b0;
            eng_gen         <= 1'b0;
            ks_valid        <= 1'b0;
            gnt             <= '0;
            case (state)
                IDLE, KEYLOAD: begin
                    if (key_valid) begin
                        eng_key_we   <= 1'b1;
                        eng_key_addr <= cnt;
                        eng_key_data <= key_in;
                        if (cnt == AW'(KEY_LEN - 1)) begin
                            cnt   <= '0;
                            state <= SETUP;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= KEYLOAD;
                        end
                    end
                end
                SETUP: begin
                    eng_setup_start <= 1'b1;
                    wd              <= '0;
                    state           <= WAITSETUP;
                end
                WAITSETUP: begin
                    if (eng_setup_done) begin
                        state <= ARB;
                    end else if (wd == TW'(TIMEOUT - 1)) begin
                        state <= ERROR;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ARB: begin
                    if (|req) begin
                        sel   <= pick;
                        ptr   <= pick;
                        state <= GEN;
                    end else if (rekey) begin
                        cnt   <= '0;
                        state <= KEYLOAD;
                    end else if (finish) begin
                        state <= DONE;
                    end
                end
                GEN: begin
                    eng_gen <= 1'b1;
                    wd      <= '0;
                    state   <= WAITKS;
                end
                WAITKS: begin
                    if (eng_ks_valid) begin
                        ks_out   <= eng_ks;
                        ks_valid <= 1'b1;
                        gnt[sel] <= 1'b1;
                        state    <= ARB;
                    end else if (wd == TW'(TIMEOUT - 1)) begin
                        state <= ERROR;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    if (rekey) begin
                        cnt   <= '0;
                        state <= KEYLOAD;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags are pure decodes of the state register.
    assign busy = !(state inside {IDLE, DONE, ERROR});
    assign done = (state == DONE);
    assign err  = (state == ERROR);

endmodule

// File: tb/tb_rc4_keystream_arbiter.sv
// tb_rc4_keystream_arbiter: drives key loads, directed and randomized request
// traffic against an engine model, and checks grants, keystream bytes and key
// writes against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_rc4_keystream_arbiter;

    localparam int KEY_LEN = 32;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 255;
    localparam int TW      = 8;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        key_valid = 1'b0;
    logic [7:0]                  key_in = '0;
    logic                        rekey = 1'b0;
    logic                        finish = 1'b0;
    logic [NREQ-1:0]             req = '0;
    logic [NREQ-1:0]             gnt;
    logic                        ks_valid;
    logic [7:0]                  ks_out;
    logic                        eng_key_we;
    logic [$clog2(KEY_LEN)-1:0]  eng_key_addr;
    logic [7:0]                  eng_key_data;
    logic                        eng_setup_start;
    logic                        eng_setup_done = 1'b0;
    logic                        eng_gen;
    logic                        eng_ks_valid = 1'b0;
    logic [7:0]                  eng_ks = '0;
    logic                        busy;
    logic                        done;
    logic                        err;

    rc4_keystream_arbiter #(
        .KEY_LEN (KEY_LEN),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .key_valid       (key_valid),
        .key_in          (key_in),
        .rekey           (rekey),
        .finish          (finish),
        .req             (req),
        .gnt             (gnt),
        .ks_valid        (ks_valid),
        .ks_out          (ks_out),
        .eng_key_we      (eng_key_we),
        .eng_key_addr    (eng_key_addr),
        .eng_key_data    (eng_key_data),
        .eng_setup_start (eng_setup_start),
        .eng_setup_done  (eng_setup_done),
        .eng_gen         (eng_gen),
        .eng_ks_valid    (eng_ks_valid),
        .eng_ks          (eng_ks),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-robin rule: first set request searching from p+1 modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        int rv;
        rv = 32'(r);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (((rv >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    // Engine model state
    int          eng_lat     = 1;
    bit          eng_respond = 1'b1;
    bit          rand_lat    = 1'b0;
    int          cur_lat     = 1;
    int          ks_wait     = 0;
    int          sd_wait     = 0;
    logic [7:0]  eng_last_byte = '0;
    logic [7:0]  eng_q[$];

    // Engine model: setup_done 5 cycles after start, keystream byte cur_lat cycles after gen.
    always @(negedge clk) begin
        #1;
        eng_ks_valid   = 1'b0;
        eng_setup_done = 1'b0;
        if (rst) begin
            ks_wait = 0;
            sd_wait = 0;
        end else begin
            if (sd_wait > 0) begin
                sd_wait--;
                if (sd_wait == 0) eng_setup_done = 1'b1;
            end
            if (ks_wait > 0) begin
                ks_wait--;
                if (ks_wait == 0) begin
                    if (eng_q.size() > 0) eng_last_byte = eng_q.pop_front();
                    else                  eng_last_byte = 8'($urandom);
                    eng_ks       = eng_last_byte;
                    eng_ks_valid = 1'b1;
                end
            end
            if (eng_setup_start) sd_wait = 5;
            if (eng_gen && eng_respond) begin
                cur_lat = rand_lat ? int'($urandom_range(1, 4)) : eng_lat;
                ks_wait = cur_lat;
            end
        end
    end

    // Scoreboard state
    int               cyc = 0;
    logic [NREQ-1:0]  req_last = '0;
    logic [NREQ-1:0]  gen_req = '0;
    bit               gen_pending = 1'b0;
    int               gen_cyc = 0;
    int               m_ptr = NREQ - 1;
    logic [7:0]       last_ks = '0;
    int               nwrites = 0;
    int               nstarts = 0;
    int               last_we_cyc = -10;
    int               exp_wr_q[$];

    // Compare process: checks every output event against the transaction model.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            gen_pending = 1'b0;
            m_ptr       = NREQ - 1;
            last_ks     = '0;
        end else begin
            if (eng_gen) begin
                chk("gen_overlap", 32'(gen_pending), 0);
                gen_pending = 1'b1;
                gen_cyc     = cyc;
                gen_req     = req_last;
            end
            if (ks_valid) begin
                int          ei;
                logic [31:0] eg;
                ei = rr_pick(gen_req, m_ptr);
                eg = (ei < 0) ? 32'd0 : (32'd1 << ei);
                chk("ks_solicited", 32'(gen_pending), 1);
                chk("gnt", 32'(gnt), eg);
                chk("ks_out", 32'(ks_out), 32'(eng_last_byte));
                chk("ks_latency", cyc - gen_cyc, cur_lat + 1);
                if (ei >= 0) m_ptr = ei;
                gen_pending = 1'b0;
                last_ks     = eng_last_byte;
            end else begin
                chk("gnt_idle", 32'(gnt), 0);
                chk("ks_hold", 32'(ks_out), 32'(last_ks));
            end
            if (eng_key_we) begin
                if (exp_wr_q.size() == 0) begin
                    chk("key_we_unexpected", 1, 0);
                end else begin
                    int e;
                    e = exp_wr_q.pop_front();
                    chk("key_addr", 32'(eng_key_addr), 32'(e >> 8));
                    chk("key_data", 32'(eng_key_data), 32'(e & 255));
                end
                nwrites++;
                last_we_cyc = cyc;
            end
            if (eng_setup_start) begin
                chk("start_after_last_write", cyc, last_we_cyc + 1);
                nstarts++;
            end
        end
        req_last = req;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_key(input bit incr, input int pause_after);
        int w0;
        int s0;
        w0 = nwrites;
        s0 = nstarts;
        for (int k = 0; k < KEY_LEN; k++) begin
            logic [7:0] d;
            d = incr ? 8'(k) : 8'($urandom);
            exp_wr_q.push_back((k << 8) | int'(d));
            step();
            key_valid = 1'b1;
            key_in    = d;
            if (k == 5) chk("busy_load", 32'(busy), 1);
            if (k == pause_after) begin
                step();
                key_valid = 1'b0;
                step();
                step();
            end
        end
        step();
        key_valid = 1'b0;
        repeat (10) step();
        chk("key_writes", nwrites - w0, KEY_LEN);
        chk("setup_starts", nstarts - s0, 1);
        chk("key_queue_empty", exp_wr_q.size(), 0);
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] g, output int at, input int budget);
        g  = '0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ks_valid) begin
                g  = gnt;
                at = cyc;
                return;
            end
        end
        chk("wait_gnt_timeout", 0, 1);
    endtask

    task automatic wait_gen(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (eng_gen) return;
        end
        chk("wait_gen_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] drop;
        logic [NREQ-1:0] raise;
        int              at;
        int              prev_at;

        #1 rst = 1'b1;
        repeat (2) step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ks_valid", 32'(ks_valid), 0);
        chk("rst_ks_out", 32'(ks_out), 0);
        chk("rst_key_we", 32'(eng_key_we), 0);
        chk("rst_key_addr", 32'(eng_key_addr), 0);
        chk("rst_setup_start", 32'(eng_setup_start), 0);
        chk("rst_gen", 32'(eng_gen), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        step();

        // Incrementing key with a 3-cycle gap after byte 10
        load_key(1'b1, 10);
        chk("arb_busy", 32'(busy), 1);
        chk("arb_done", 32'(done), 0);

        // Round-robin with both requesters held
        eng_q.push_back(8'h10);
        eng_q.push_back(8'h11);
        eng_q.push_back(8'h12);
        eng_q.push_back(8'h13);
        req     = 2'b11;
        prev_at = 0;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(g, at, 20);
            if (n == 3) req = '0;
            chk($sformatf("rr_gnt%0d", n), 32'(g), (n % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr_ks%0d", n), 32'(ks_out), 32'h10 + 32'(n));
            if (n > 0) chk("rr_spacing", at - prev_at, 4);
            prev_at = at;
        end

        // Single request
        step();
        eng_q.push_back(8'hA5);
        req = 2'b01;
        wait_gnt(g, at, 20);
        req = '0;
        chk("single_gnt", 32'(g), 1);
        chk("single_ks", 32'(ks_out), 32'hA5);
        chk("model_ptr", m_ptr, 0);
        step();
        chk("ks_pulse", 32'(ks_valid), 0);

        // Request beats finish in the same ARB cycle, then DONE, then rekey
        step();
        finish = 1'b1;
        req    = 2'b10;
        wait_gnt(g, at, 20);
        req = '0;
        chk("fin_gnt", 32'(g), 2);
        chk("fin_done_before", 32'(done), 0);
        step();
        step();
        chk("done_high", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        step();
        finish = 1'b0;
        rekey  = 1'b1;
        step();
        rekey = 1'b0;
        chk("rekey_done", 32'(done), 0);
        chk("rekey_busy", 32'(busy), 1);
        load_key(1'b0, -1);

        // Randomized traffic with variable engine latency
        rand_lat = 1'b1;
        for (int c = 0; c < 400; c++) begin
            step();
            drop  = ks_valid ? gnt : '0;
            raise = NREQ'($urandom) & NREQ'($urandom);
            req   = (req & ~drop) | (raise & ~drop);
        end
        for (int c = 0; c < 200 && req != '0; c++) begin
            step();
            if (ks_valid) req = req & ~gnt;
        end
        chk("drain", 32'(req), 0);
        rand_lat = 1'b0;
        repeat (3) step();

        // Watchdog: engine never answers
        eng_respond = 1'b0;
        req = 2'b01;
        wait_gen(10);
        repeat (254) step();
        chk("wd_err_early", 32'(err), 0);
        step();
        chk("wd_err", 32'(err), 1);
        chk("wd_no_ks", 32'(ks_valid), 0);
        chk("wd_busy", 32'(busy), 0);
        rekey = 1'b1;
        step();
        rekey = 1'b0;
        step();
        chk("wd_err_sticky", 32'(err), 1);
        rst = 1'b1;
        step();
        chk("wd_rst_err", 32'(err), 0);
        rst = 1'b0;
        req = '0;
        eng_respond = 1'b1;

        // Async reset while waiting on a slow engine
        load_key(1'b0, -1);
        eng_q.push_back(8'h5C);
        req = 2'b01;
        wait_gnt(g, at, 20);
        req = '0;
        chk("ar_pre_ks", 32'(ks_out), 32'h5C);
        step();
        eng_lat = 20;
        req = 2'b10;
        wait_gen(10);
        step();
        step();
        chk("ar_busy_before", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_gnt", 32'(gnt), 0);
        chk("ar_ks_valid", 32'(ks_valid), 0);
        chk("ar_ks_out", 32'(ks_out), 0);
        chk("ar_key_addr", 32'(eng_key_addr), 0);
        chk("ar_key_data", 32'(eng_key_data), 0);
        chk("ar_gen", 32'(eng_gen), 0);
        chk("ar_err", 32'(err), 0);
        step();
        rst     = 1'b0;
        req     = '0;
        eng_lat = 1;
        load_key(1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
